// File: rtl/ft245_fifo_responder.sv
// ft245_fifo_responder: FT245-style chip-side responder bridging RD/WR strobes to host-side RX/TX byte FIFOs.
// Define FT_ERRCNT_EN to add saturating RD_ERR/WR_ERR violation counters.
module ft245_fifo_responder #(
   parameter int DEPTH_LOG2 = 7,
   parameter int RXF_HOLD   = 4,
   parameter int TXE_HOLD   = 4
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  RD,
   input  logic                  WR,
   input  logic [7:0]            USB_DIN,
   output logic [7:0]            USB_DOUT,
   output logic                  USB_OE,
   output logic                  RXF,
   output logic                  TXE,
   input  logic [7:0]            HRX_DATA,
   input  logic                  HRX_VALID,
   output logic                  HRX_READY,
   output logic [7:0]            HTX_DATA,
   output logic                  HTX_VALID,
   input  logic                  HTX_READY,
   output logic [DEPTH_LOG2:0]   RX_LEVEL,
   output logic [DEPTH_LOG2:0]   TX_LEVEL
`ifdef FT_ERRCNT_EN
   ,
   output logic [7:0]            RD_ERR,
   output logic [7:0]            WR_ERR
`endif
);
   localparam int LW = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL = LW'(DEPTH);
   localparam logic [7:0] RXF_H = 8'(RXF_HOLD);
   localparam logic [7:0] TXE_H = 8'(TXE_HOLD);
   typedef enum logic {R_IDLE, R_DRIVE} r_st_t;
   typedef enum logic {W_IDLE, W_CAPT} w_st_t;
   logic rd_s1_q, rd_s2_q, wr_s1_q, wr_s2_q;
   logic [7:0] din_s1_q, din_s2_q;
   logic [7:0] rx_mem [DEPTH];
   logic [7:0] tx_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d, tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [DEPTH_LOG2:0] rx_lvl_q, rx_lvl_d, tx_lvl_q, tx_lvl_d;
   r_st_t r_st_q, r_st_d;
   w_st_t w_st_q, w_st_d;
   logic rd_hit_q, rd_hit_d, oe_q, oe_d, rxf_q, rxf_d, txe_q, txe_d;
   logic [7:0] dout_q, dout_d, cap_q, cap_d, rxf_cnt_q, rxf_cnt_d, txe_cnt_q, txe_cnt_d;
   logic rx_push, rx_pop, tx_push, tx_pop;
   always_comb begin
      rx_push = HRX_VALID && rx_lvl_q != FULL;
      tx_pop = tx_lvl_q != '0 && HTX_READY;
      rx_pop = 1'b0;
      tx_push = 1'b0;
      r_st_d = r_st_q;
      w_st_d = w_st_q;
      rd_hit_d = rd_hit_q;
      dout_d = dout_q;
      oe_d = oe_q;
      cap_d = cap_q;
      rxf_cnt_d = rxf_cnt_q != 8'd0 ? rxf_cnt_q - 8'd1 : 8'd0;
      txe_cnt_d = txe_cnt_q != 8'd0 ? txe_cnt_q - 8'd1 : 8'd0;
      // rd_hit remembers whether the byte on the bus came from the FIFO, so an empty read never pops
      if (r_st_q == R_IDLE && !rd_s2_q) begin
         r_st_d = R_DRIVE;
         oe_d = 1'b1;
         rd_hit_d = rx_lvl_q != '0;
         dout_d = rx_lvl_q != '0 ? rx_mem[rx_rp_q] : 8'h00;
      end else if (r_st_q == R_DRIVE && rd_s2_q) begin
         r_st_d = R_IDLE;
         oe_d = 1'b0;
         rx_pop = rd_hit_q;
         rxf_cnt_d = RXF_H;
      end
      if (wr_s2_q) begin
         w_st_d = W_CAPT;
         cap_d = din_s2_q;
      end else if (w_st_q == W_CAPT) begin
         w_st_d = W_IDLE;
         tx_push = tx_lvl_q != FULL;
         txe_cnt_d = TXE_H;
      end
      rx_wp_d = rx_push ? rx_wp_q + 1'b1 : rx_wp_q;
      rx_rp_d = rx_pop ? rx_rp_q + 1'b1 : rx_rp_q;
      tx_wp_d = tx_push ? tx_wp_q + 1'b1 : tx_wp_q;
      tx_rp_d = tx_pop ? tx_rp_q + 1'b1 : tx_rp_q;
      rx_lvl_d = rx_lvl_q + LW'(rx_push) - LW'(rx_pop);
      tx_lvl_d = tx_lvl_q + LW'(tx_push) - LW'(tx_pop);
      rxf_d = rxf_cnt_d != 8'd0 || rx_lvl_d == '0;
      txe_d = txe_cnt_d != 8'd0 || tx_lvl_d == FULL;
   end
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         rd_s1_q <= 1'b1;
         rd_s2_q <= 1'b1;
         wr_s1_q <= 1'b0;
         wr_s2_q <= 1'b0;
         din_s1_q <= 8'h00;
         din_s2_q <= 8'h00;
         rx_wp_q <= '0;
         rx_rp_q <= '0;
         tx_wp_q <= '0;
         tx_rp_q <= '0;
         rx_lvl_q <= '0;
         tx_lvl_q <= '0;
         r_st_q <= R_IDLE;
         w_st_q <= W_IDLE;
         rd_hit_q <= 1'b0;
         oe_q <= 1'b0;
         dout_q <= 8'h00;
         cap_q <= 8'h00;
         rxf_cnt_q <= 8'd0;
         txe_cnt_q <= 8'd0;
         rxf_q <= 1'b1;
         txe_q <= 1'b1;
      end else begin
         rd_s1_q <= RD;
         rd_s2_q <= rd_s1_q;
         wr_s1_q <= WR;
         wr_s2_q <= wr_s1_q;
         din_s1_q <= USB_DIN;
         din_s2_q <= din_s1_q;
         rx_wp_q <= rx_wp_d;
         rx_rp_q <= rx_rp_d;
         tx_wp_q <= tx_wp_d;
         tx_rp_q <= tx_rp_d;
         rx_lvl_q <= rx_lvl_d;
         tx_lvl_q <= tx_lvl_d;
         r_st_q <= r_st_d;
         w_st_q <= w_st_d;
         rd_hit_q <= rd_hit_d;
         oe_q <= oe_d;
         dout_q <= dout_d;
         cap_q <= cap_d;
         rxf_cnt_q <= rxf_cnt_d;
         txe_cnt_q <= txe_cnt_d;
         rxf_q <= rxf_d;
         txe_q <= txe_d;
      end
   end
   always_ff @(posedge CLK) begin
      if (rx_push) rx_mem[rx_wp_q] <= HRX_DATA;
      if (tx_push) tx_mem[tx_wp_q] <= cap_q;
   end
`ifdef FT_ERRCNT_EN
   logic rd_viol, wr_viol;
   logic [7:0] rd_err_q, rd_err_d, wr_err_q, wr_err_d;
   always_comb begin
      rd_viol = r_st_q == R_IDLE && !rd_s2_q && rx_lvl_q == '0;
      wr_viol = w_st_q == W_CAPT && !wr_s2_q && tx_lvl_q == FULL;
      rd_err_d = rd_viol && rd_err_q != 8'hFF ? rd_err_q + 8'd1 : rd_err_q;
      wr_err_d = wr_viol && wr_err_q != 8'hFF ? wr_err_q + 8'd1 : wr_err_q;
   end
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         rd_err_q <= 8'd0;
         wr_err_q <= 8'd0;
      end else begin
         rd_err_q <= rd_err_d;
         wr_err_q <= wr_err_d;
      end
   end
   assign RD_ERR = rd_err_q;
   assign WR_ERR = wr_err_q;
`endif
   assign USB_DOUT = dout_q;
   assign USB_OE = oe_q;
   assign RXF = rxf_q;
   assign TXE = txe_q;
   assign HRX_READY = rx_lvl_q != FULL;
   assign HTX_VALID = tx_lvl_q != '0;
   assign HTX_DATA = HTX_VALID ? tx_mem[tx_rp_q] : 8'h00;
   assign RX_LEVEL = rx_lvl_q;
   assign TX_LEVEL = tx_lvl_q;
endmodule

// File: tb/tb_ft245_fifo_responder.sv
// tb_ft245_fifo_responder: directed bench for ft245_fifo_responder (default depth 128, holds of 4).
module tb_ft245_fifo_responder;
   logic CLK, RSTN, RD, WR, HRX_VALID, HTX_READY;
   logic [7:0] USB_DIN, HRX_DATA;
   logic [7:0] USB_DOUT, HTX_DATA;
   logic USB_OE, RXF, TXE, HRX_READY, HTX_VALID;
   logic [7:0] RX_LEVEL, TX_LEVEL;
`ifdef FT_ERRCNT_EN
   logic [7:0] RD_ERR, WR_ERR;
`endif
   int errors = 0;
   int checks = 0;

   ft245_fifo_responder dut (
      .CLK(CLK), .RSTN(RSTN), .RD(RD), .WR(WR), .USB_DIN(USB_DIN),
      .USB_DOUT(USB_DOUT), .USB_OE(USB_OE), .RXF(RXF), .TXE(TXE),
      .HRX_DATA(HRX_DATA), .HRX_VALID(HRX_VALID), .HRX_READY(HRX_READY),
      .HTX_DATA(HTX_DATA), .HTX_VALID(HTX_VALID), .HTX_READY(HTX_READY),
      .RX_LEVEL(RX_LEVEL), .TX_LEVEL(TX_LEVEL)
`ifdef FT_ERRCNT_EN
      , .RD_ERR(RD_ERR), .WR_ERR(WR_ERR)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic wr_byte(input logic [7:0] b);
      USB_DIN = b;
      WR = 1'b1;
      tick(4);
      WR = 1'b0;
      tick(8);
   endtask

   task automatic test_reset;
      RSTN = 1'b0;
      #12;
      checks++; if (RXF !== 1'b1) begin errors++; $display("FAIL reset_rxf got %b want 1", RXF); end
      checks++; if (TXE !== 1'b1) begin errors++; $display("FAIL reset_txe got %b want 1", TXE); end
      checks++; if (USB_OE !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", USB_OE); end
      checks++; if (USB_DOUT !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", USB_DOUT); end
      checks++; if (HTX_VALID !== 1'b0) begin errors++; $display("FAIL reset_htx_valid got %b want 0", HTX_VALID); end
      checks++; if (HRX_READY !== 1'b1) begin errors++; $display("FAIL reset_hrx_ready got %b want 1", HRX_READY); end
      checks++; if (RX_LEVEL !== 8'd0 || TX_LEVEL !== 8'd0) begin errors++; $display("FAIL reset_levels got %0d/%0d want 0/0", RX_LEVEL, TX_LEVEL); end
      @(negedge CLK);
      RSTN = 1'b1;
      tick(2);
      checks++; if (TXE !== 1'b0) begin errors++; $display("FAIL reset_txe_after got %b want 0", TXE); end
   endtask

   task automatic test_rd;
      HRX_DATA = 8'h07;
      HRX_VALID = 1'b1;
      tick();
      HRX_VALID = 1'b0;
      checks++; if (RX_LEVEL !== 8'd1) begin errors++; $display("FAIL rd_level1 got %0d want 1", RX_LEVEL); end
      checks++; if (RXF !== 1'b0) begin errors++; $display("FAIL rd_rxf_low got %b want 0", RXF); end
      RD = 1'b0;
      tick(3);
      checks++; if (USB_OE !== 1'b1 || USB_DOUT !== 8'h07) begin errors++; $display("FAIL rd_drive got oe=%b dout=%h want oe=1 dout=07", USB_OE, USB_DOUT); end
      tick(2);
      checks++; if (USB_DOUT !== 8'h07) begin errors++; $display("FAIL rd_stable got %h want 07", USB_DOUT); end
      RD = 1'b1;
      tick(3);
      checks++; if (USB_OE !== 1'b0 || RX_LEVEL !== 8'd0 || RXF !== 1'b1) begin errors++; $display("FAIL rd_release got oe=%b lvl=%0d rxf=%b want 0/0/1", USB_OE, RX_LEVEL, RXF); end
      tick(6);
   endtask

   task automatic test_rxf_hold;
      HRX_VALID = 1'b1;
      HRX_DATA = 8'h11;
      tick();
      HRX_DATA = 8'h22;
      tick();
      HRX_VALID = 1'b0;
      RD = 1'b0;
      tick(5);
      checks++; if (USB_DOUT !== 8'h11) begin errors++; $display("FAIL hold_first got %h want 11", USB_DOUT); end
      RD = 1'b1;
      tick(3);
      checks++; if (RXF !== 1'b1 || RX_LEVEL !== 8'd1) begin errors++; $display("FAIL hold_start got rxf=%b lvl=%0d want 1/1", RXF, RX_LEVEL); end
      tick(3);
      checks++; if (RXF !== 1'b1) begin errors++; $display("FAIL hold_last got %b want 1", RXF); end
      tick();
      checks++; if (RXF !== 1'b0) begin errors++; $display("FAIL hold_expire got %b want 0", RXF); end
      RD = 1'b0;
      tick(5);
      checks++; if (USB_DOUT !== 8'h22) begin errors++; $display("FAIL hold_second got %h want 22", USB_DOUT); end
      RD = 1'b1;
      tick(8);
      checks++; if (RX_LEVEL !== 8'd0) begin errors++; $display("FAIL hold_drain got %0d want 0", RX_LEVEL); end
   endtask

   task automatic test_rd_empty;
      checks++; if (RXF !== 1'b1) begin errors++; $display("FAIL empty_rxf got %b want 1", RXF); end
      RD = 1'b0;
      tick(3);
      checks++; if (USB_OE !== 1'b1 || USB_DOUT !== 8'h00) begin errors++; $display("FAIL empty_drive got oe=%b dout=%h want 1/00", USB_OE, USB_DOUT); end
      tick(2);
      RD = 1'b1;
      tick(8);
      checks++; if (RX_LEVEL !== 8'd0 || USB_OE !== 1'b0) begin errors++; $display("FAIL empty_level got lvl=%0d oe=%b want 0/0", RX_LEVEL, USB_OE); end
`ifdef FT_ERRCNT_EN
      checks++; if (RD_ERR !== 8'd1) begin errors++; $display("FAIL empty_rd_err got %0d want 1", RD_ERR); end
`endif
   endtask

   task automatic test_tx_fill;
      wr_byte(8'h00);
      checks++; if (TX_LEVEL !== 8'd1 || HTX_VALID !== 1'b1 || HTX_DATA !== 8'h00) begin errors++; $display("FAIL tx_first got lvl=%0d v=%b d=%h want 1/1/00", TX_LEVEL, HTX_VALID, HTX_DATA); end
      checks++; if (TXE !== 1'b0) begin errors++; $display("FAIL tx_txe_low got %b want 0", TXE); end
      for (int i = 1; i < 128; i++) wr_byte(8'(i));
      checks++; if (TX_LEVEL !== 8'd128) begin errors++; $display("FAIL tx_full_level got %0d want 128", TX_LEVEL); end
      checks++; if (TXE !== 1'b1) begin errors++; $display("FAIL tx_full_txe got %b want 1", TXE); end
      wr_byte(8'hAA);
      checks++; if (TX_LEVEL !== 8'd128 || TXE !== 1'b1) begin errors++; $display("FAIL tx_overflow got lvl=%0d txe=%b want 128/1", TX_LEVEL, TXE); end
`ifdef FT_ERRCNT_EN
      checks++; if (WR_ERR !== 8'd1) begin errors++; $display("FAIL tx_wr_err got %0d want 1", WR_ERR); end
`endif
      for (int i = 0; i < 128; i++) begin
         checks++; if (HTX_VALID !== 1'b1 || HTX_DATA !== 8'(i)) begin errors++; $display("FAIL tx_pop_%0d got v=%b d=%h want 1/%h", i, HTX_VALID, HTX_DATA, 8'(i)); end
         HTX_READY = 1'b1;
         tick();
      end
      HTX_READY = 1'b0;
      checks++; if (TX_LEVEL !== 8'd0 || HTX_VALID !== 1'b0 || TXE !== 1'b0) begin errors++; $display("FAIL tx_drained got lvl=%0d v=%b txe=%b want 0/0/0", TX_LEVEL, HTX_VALID, TXE); end
   endtask

   task automatic test_rx_boundary;
      HRX_VALID = 1'b1;
      for (int i = 0; i < 127; i++) begin
         HRX_DATA = 8'(i);
         tick();
      end
      HRX_VALID = 1'b0;
      checks++; if (RX_LEVEL !== 8'd127 || HRX_READY !== 1'b1) begin errors++; $display("FAIL bnd_127 got lvl=%0d rdy=%b want 127/1", RX_LEVEL, HRX_READY); end
      RD = 1'b0;
      tick(5);
      checks++; if (USB_DOUT !== 8'h00) begin errors++; $display("FAIL bnd_head0 got %h want 00", USB_DOUT); end
      RD = 1'b1;
      tick(2);
      HRX_DATA = 8'hC8;
      HRX_VALID = 1'b1;
      tick();
      HRX_VALID = 1'b0;
      checks++; if (RX_LEVEL !== 8'd127) begin errors++; $display("FAIL bnd_pushpop got %0d want 127", RX_LEVEL); end
      HRX_VALID = 1'b1;
      tick();
      checks++; if (RX_LEVEL !== 8'd128 || HRX_READY !== 1'b0) begin errors++; $display("FAIL bnd_full got lvl=%0d rdy=%b want 128/0", RX_LEVEL, HRX_READY); end
      RD = 1'b0;
      tick(5);
      checks++; if (USB_DOUT !== 8'h01) begin errors++; $display("FAIL bnd_head1 got %h want 01", USB_DOUT); end
      RD = 1'b1;
      tick(2);
      checks++; if (HRX_READY !== 1'b0) begin errors++; $display("FAIL bnd_ready_pop got %b want 0", HRX_READY); end
      tick();
      HRX_VALID = 1'b0;
      checks++; if (RX_LEVEL !== 8'd127 || HRX_READY !== 1'b1) begin errors++; $display("FAIL bnd_after_pop got lvl=%0d rdy=%b want 127/1", RX_LEVEL, HRX_READY); end
   endtask

   task automatic test_reset_mid;
      RD = 1'b0;
      tick(3);
      checks++; if (USB_OE !== 1'b1) begin errors++; $display("FAIL mid_oe_before got %b want 1", USB_OE); end
      #2 RSTN = 1'b0;
      #1;
      checks++; if (USB_OE !== 1'b0 || RXF !== 1'b1 || TXE !== 1'b1) begin errors++; $display("FAIL mid_async got oe=%b rxf=%b txe=%b want 0/1/1", USB_OE, RXF, TXE); end
      checks++; if (RX_LEVEL !== 8'd0 || TX_LEVEL !== 8'd0) begin errors++; $display("FAIL mid_levels got %0d/%0d want 0/0", RX_LEVEL, TX_LEVEL); end
      RD = 1'b1;
      tick(2);
      RSTN = 1'b1;
      HRX_DATA = 8'h3C;
      HRX_VALID = 1'b1;
      tick();
      HRX_VALID = 1'b0;
      tick(6);
      checks++; if (RX_LEVEL !== 8'd1 || USB_OE !== 1'b0) begin errors++; $display("FAIL mid_no_pop got lvl=%0d oe=%b want 1/0", RX_LEVEL, USB_OE); end
      RD = 1'b0;
      tick(5);
      checks++; if (USB_DOUT !== 8'h3C) begin errors++; $display("FAIL mid_read got %h want 3c", USB_DOUT); end
      RD = 1'b1;
      tick(4);
      checks++; if (RX_LEVEL !== 8'd0) begin errors++; $display("FAIL mid_drain got %0d want 0", RX_LEVEL); end
   endtask

   initial begin
      RD = 1'b1;
      WR = 1'b0;
      USB_DIN = 8'h00;
      HRX_DATA = 8'h00;
      HRX_VALID = 1'b0;
      HTX_READY = 1'b0;
      test_reset();
      test_rd();
      test_rxf_hold();
      test_rd_empty();
      test_tx_fill();
      test_rx_boundary();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
